// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl
// Purpose  : Request/response front end for an external byte stack. Accepts
//            clr/push/pop requests from a host, issues one registered command
//            to the stack, checks the stack's status flags against its own
//            occupancy count, and returns a single-cycle response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   req_valid  in   1  host request present
//   req_ready  out  1  request accepted this cycle (IDLE only)
//   req_op     in   2  01 clr, 10 push, 11 pop, 00 illegal
//   req_data   in   8  byte to push
//   rsp_valid  out  1  one-cycle response strobe
//   rsp_data   out  8  popped byte, 0 for every other response
//   rsp_err    out  1  request rejected locally or failed in the stack
//   level      out  4  occupancy count, 0..DEPTH
//   desync     out  1  sticky: stack flags disagreed with level
//   stk_cmd    out  2  stack command: 00 nop, 01 clr, 10 push, 11 pop
//   stk_din    out  8  byte presented to the stack's data_in
//   stk_dout   in   8  stack data_out
//   stk_full   in   1  stack full flag
//   stk_empty  in   1  stack empty flag
//   stk_error  in   1  stack error flag
// ============================================================================
module stack_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] level,
  output logic       desync,
  output logic [1:0] stk_cmd,
  output logic [7:0] stk_din,
  input  logic [7:0] stk_dout,
  input  logic       stk_full,
  input  logic       stk_empty,
  input  logic       stk_error
);

  localparam logic [1:0] C_OP_NOP  = 2'b00;
  localparam logic [1:0] C_OP_CLR  = 2'b01;
  localparam logic [1:0] C_OP_PUSH = 2'b10;
  localparam logic [1:0] C_OP_POP  = 2'b11;
  localparam logic [3:0] C_LVL_MAX = 4'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_CMD  = 3'd2,
    S_CHK  = 3'd3,
    S_DATA = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t     r_state;
  logic       r_init_step;  // INIT takes two edges: drop clr, then check empty
  logic [1:0] r_op;         // opcode of the request in flight
  logic       r_err;        // stk_error captured in CHK, held for pop's DATA

  logic       w_reject;
  logic [3:0] w_next_level;
  logic       w_chk_bad;

  // Requests the controller refuses without touching the stack.
  always_comb begin
    w_reject = 1'b0;
    case (req_op)
      C_OP_NOP:  w_reject = 1'b1;
      C_OP_PUSH: w_reject = (level == C_LVL_MAX);
      C_OP_POP:  w_reject = (level == 4'd0);
      default:   w_reject = 1'b0;
    endcase
  end

  // Occupancy after the in-flight command. Rejects guarantee no wrap here.
  always_comb begin
    w_next_level = level;
    case (r_op)
      C_OP_CLR:  w_next_level = 4'd0;
      C_OP_PUSH: w_next_level = level + 4'd1;
      C_OP_POP:  w_next_level = level - 4'd1;
      default:   w_next_level = level;
    endcase
  end

  // The stack's flags must agree with the level we are about to hold.
  assign w_chk_bad = stk_error
                   | (stk_full  != (w_next_level == C_LVL_MAX))
                   | (stk_empty != (w_next_level == 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_step <= 1'b0;
      r_op        <= C_OP_NOP;
      r_err       <= 1'b0;
      stk_cmd     <= C_OP_CLR;  // keep the stack cleared while in reset
      stk_din     <= 8'h00;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= 8'h00;
      level       <= 4'd0;
      desync      <= 1'b0;
    end else begin
      // Commands and responses are single-cycle pulses unless re-armed below.
      stk_cmd   <= C_OP_NOP;
      rsp_valid <= 1'b0;

      case (r_state)
        S_INIT: begin
          if (!r_init_step) begin
            r_init_step <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            if (!stk_empty) begin
              desync <= 1'b1;
            end
          end
        end

        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_op      <= req_op;
            req_ready <= 1'b0;
            if (w_reject) begin
              r_state   <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 8'h00;
            end else begin
              stk_cmd <= req_op;
              stk_din <= req_data;
              r_state <= S_CMD;
            end
          end
        end

        // The stack samples stk_cmd on the edge leaving CMD.
        S_CMD: begin
          r_state <= S_CHK;
        end

        S_CHK: begin
          level <= w_next_level;
          r_err <= stk_error;
          if (w_chk_bad) begin
            desync <= 1'b1;
          end else if (r_op == C_OP_CLR) begin
            desync <= 1'b0;
          end
          if (r_op == C_OP_POP) begin
            r_state <= S_DATA;
          end else begin
            r_state   <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= stk_error;
            rsp_data  <= 8'h00;
          end
        end

        S_DATA: begin
          r_state   <= S_RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= r_err;
          rsp_data  <= stk_dout;
        end

        // rsp_valid is high for the whole RSP cycle; clean up on exit.
        S_RSP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= 8'h00;
        end

        default: begin
          r_state     <= S_INIT;
          r_init_step <= 1'b0;
          req_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_ctrl
// Purpose  : Self-checking bench for stack_ctrl with a behavioural byte stack.
//            Each request pushes its expected response into a scoreboard; a
//            monitor pops and compares whenever rsp_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] level;
  logic       desync;
  logic [1:0] stk_cmd;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .level(level), .desync(desync),
    .stk_cmd(stk_cmd), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error)
  );

  // Behavioural 8-byte stack; acts on stk_cmd at each rising edge.
  logic [7:0] mem [0:7];
  int         sp = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_err = 1'b0;
  logic       force_full = 1'b0;

  always @(posedge clk) begin
    m_err <= 1'b0;
    case (stk_cmd)
      2'b01: sp <= 0;
      2'b10: if (sp >= 8) m_err <= 1'b1;
             else begin mem[sp] <= stk_din; sp <= sp + 1; end
      2'b11: if (sp == 0) m_err <= 1'b1;
             else begin m_dout <= mem[sp-1]; sp <= sp - 1; end
      default: ;
    endcase
  end

  assign stk_dout  = m_dout;
  assign stk_error = m_err;
  assign stk_full  = (sp == 8) | force_full;
  assign stk_empty = (sp == 0);

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         at_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, want no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  // Assert reset for two cycles, then walk through INIT.
  task automatic reset_seq();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stk_cmd", 32'(stk_cmd), 32'h1);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_desync", 32'(desync), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("init1_stk_cmd", 32'(stk_cmd), 32'h0);
    chk("init1_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("init2_ready", 32'(req_ready), 32'h1);
    chk("init2_level", 32'(level), 32'h0);
    chk("init2_desync", 32'(desync), 32'h0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=%b, want 1 within 50 cycles", req_ready);
    end
  endtask

  // Issue one request from a negedge; lat is accept-edge-to-sampled-rsp cycles.
  task automatic do_req(input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] ed, input logic ee,
                        input int lat, input bit issued);
    exp_t e;
    wait_ready();
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    e.data   = ed;
    e.err    = ee;
    e.at_cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (issued) begin
      chk("stk_cmd_issue", 32'(stk_cmd), 32'(op));
      chk("stk_din_issue", 32'(stk_din), 32'(d));
    end else begin
      chk("stk_cmd_reject", 32'(stk_cmd), 32'h0);
    end
    @(negedge clk);
    chk("stk_cmd_back_nop", 32'(stk_cmd), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 8'h00;

    // Reset and initial state
    reset_seq();

    // Forced full flag on the first push sets desync; a clean clr clears it
    force_full = 1'b1;
    do_req(2'b10, 8'h11, 8'h00, 1'b0, 3, 1'b1);
    wait_ready();
    force_full = 1'b0;
    chk("desync_set", 32'(desync), 32'h1);
    do_req(2'b10, 8'h22, 8'h00, 1'b0, 3, 1'b1);
    wait_ready();
    chk("desync_held", 32'(desync), 32'h1);
    chk("desync_level2", 32'(level), 32'h2);
    do_req(2'b01, 8'h00, 8'h00, 1'b0, 3, 1'b1);
    wait_ready();
    chk("desync_cleared", 32'(desync), 32'h0);
    chk("clr_level", 32'(level), 32'h0);

    // Push A5 then pop it back
    do_req(2'b10, 8'hA5, 8'h00, 1'b0, 3, 1'b1);
    wait_ready();
    chk("a5_level1", 32'(level), 32'h1);
    do_req(2'b11, 8'h00, 8'hA5, 1'b0, 4, 1'b1);
    wait_ready();
    chk("a5_level0", 32'(level), 32'h0);

    // Fill to DEPTH, overflow reject, then drain in LIFO order
    for (int i = 1; i <= 8; i++) begin
      do_req(2'b10, 8'(i), 8'h00, 1'b0, 3, 1'b1);
    end
    wait_ready();
    chk("full_level", 32'(level), 32'h8);
    do_req(2'b10, 8'h09, 8'h00, 1'b1, 1, 1'b0);
    wait_ready();
    chk("overflow_level", 32'(level), 32'h8);
    for (int i = 8; i >= 1; i--) begin
      do_req(2'b11, 8'h00, 8'(i), 1'b0, 4, 1'b1);
    end
    wait_ready();
    chk("drained_level", 32'(level), 32'h0);

    // Pop on empty and illegal opcode
    do_req(2'b11, 8'h00, 8'h00, 1'b1, 1, 1'b0);
    do_req(2'b00, 8'h77, 8'h00, 1'b1, 1, 1'b0);
    wait_ready();
    chk("reject_level", 32'(level), 32'h0);
    chk("reject_desync", 32'(desync), 32'h0);

    // Reset while a pop sits in DATA: no response, clean restart
    do_req(2'b10, 8'h33, 8'h00, 1'b0, 3, 1'b1);
    do_req(2'b10, 8'h44, 8'h00, 1'b0, 3, 1'b1);
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b11;
    @(negedge clk);        // CMD
    req_valid = 1'b0;
    @(negedge clk);        // CHK
    @(negedge clk);        // DATA
    chk("abort_level_in_data", 32'(level), 32'h1);
    reset_seq();
    wait_ready();
    chk("after_abort_level", 32'(level), 32'h0);

    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
